// File: rtl/jtframe_test_inputs_if.sv
// Player-input bundle between the frame (master) and the scripted input generator (slave).
// All control outputs are active low.
interface jtframe_test_inputs_if;
  logic       loop_rst;
  logic       lvbl;
  logic [6:0] game_joystick1;
  logic       button_1p;
  logic       coin_left;

  modport master (
    output loop_rst,
    output lvbl,
    input  game_joystick1,
    input  button_1p,
    input  coin_left
  );

  modport slave (
    input  loop_rst,
    input  lvbl,
    output game_joystick1,
    output button_1p,
    output coin_left
  );
endinterface

// File: rtl/jtframe_test_inputs.sv
// Scripted player-1 input generator for simulation. Plays a fixed table of
// {frames, act} steps, paced by LVBL falling edges. Outputs are active low.
// Optional feature: define JTFRAME_TEST_INPUTS_LOOP_EN to repeat steps S5..S7
// forever instead of stopping in the done state after S7.
module jtframe_test_inputs #(
  parameter int unsigned CntW = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  jtframe_test_inputs_if.slave  ctrl_io
);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  localparam logic [2:0] LastIdx = 3'd7;
  localparam logic [2:0] LoopIdx = 3'd5;

  // Step lengths in frames; every entry must be non-zero and fit in CntW bits.
  function automatic logic [CntW-1:0] step_frames(input logic [2:0] idx);
    case (idx)
      3'd0:    step_frames = CntW'(60);
      3'd1:    step_frames = CntW'(4);
      3'd2:    step_frames = CntW'(30);
      3'd3:    step_frames = CntW'(4);
      3'd4:    step_frames = CntW'(120);
      3'd5:    step_frames = CntW'(30);
      3'd6:    step_frames = CntW'(10);
      default: step_frames = CntW'(30);
    endcase
  endfunction

  // Active-high {coin, start, joy[6:0]} for each step.
  function automatic logic [8:0] step_act(input logic [2:0] idx);
    case (idx)
      3'd1:    step_act = 9'h100;
      3'd3:    step_act = 9'h080;
      3'd5:    step_act = 9'h001;
      3'd6:    step_act = 9'h010;
      3'd7:    step_act = 9'h002;
      default: step_act = 9'h000;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      act_q, act_d;
  logic            lvbl_l_q, lvbl_l_d;
  logic            frame_tick;
  logic [2:0]      nxt_idx;

  assign frame_tick = lvbl_l_q & ~ctrl_io.lvbl;

  // Next-state: restart has priority over a frame tick; ticks only count while running.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    lvbl_l_d = ctrl_io.lvbl;
    nxt_idx  = idx_q + 3'd1;
    if (ctrl_io.loop_rst) begin
      state_d = StRun;
      idx_d   = 3'd0;
      cnt_d   = step_frames(3'd0);
      act_d   = '0;
    end else if (state_q == StRun && frame_tick) begin
      if (cnt_q == CntW'(1)) begin
        if (idx_q == LastIdx) begin
`ifdef JTFRAME_TEST_INPUTS_LOOP_EN
          idx_d = LoopIdx;
          cnt_d = step_frames(LoopIdx);
          act_d = step_act(LoopIdx);
`else
          state_d = StDone;
          act_d   = '0;
`endif
        end else begin
          idx_d = nxt_idx;
          cnt_d = step_frames(nxt_idx);
          act_d = step_act(nxt_idx);
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // State registers; reset releases every control asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      idx_q    <= 3'd0;
      cnt_q    <= CntW'(60);
      act_q    <= '0;
      lvbl_l_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      lvbl_l_q <= lvbl_l_d;
    end
  end

  assign ctrl_io.game_joystick1 = ~act_q[6:0];
  assign ctrl_io.button_1p      = ~act_q[7];
  assign ctrl_io.coin_left      = ~act_q[8];

endmodule

// File: tb/tb_jtframe_test_inputs.sv
// Bench for jtframe_test_inputs: table of expected outputs at given tick counts,
// a per-cycle reference model driven by tick counting, directed corner cases
// and randomized frame timing with random script restarts.
module tb_jtframe_test_inputs;

  logic clk_i = 1'b0;
  logic rst_ni;

  jtframe_test_inputs_if ctrl_if ();

  jtframe_test_inputs #(
    .CntW (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .ctrl_io (ctrl_if)
  );

  always #5 clk_i = ~clk_i;

  int   total = 0;
  int   bad = 0;
  int   ticks = 0;
  logic prev_lvbl = 1'b1;

  typedef struct {
    int         edges;
    logic [8:0] act;
  } vec_t;

  vec_t vecs[18];

  // Expected active-high {coin, start, joy} after t counted ticks since (re)start.
  function automatic logic [8:0] model_act(input int t);
    logic [8:0] a;
    a = 9'h000;
    if (t >= 60 && t < 64)        a = 9'h100;
    else if (t >= 94 && t < 98)   a = 9'h080;
    else if (t >= 218 && t < 248) a = 9'h001;
    else if (t >= 248 && t < 258) a = 9'h010;
    else if (t >= 258 && t < 288) a = 9'h002;
    else if (t >= 288) begin
`ifdef JTFRAME_TEST_INPUTS_LOOP_EN
      int p;
      p = (t - 288) % 70;
      if (p < 30)      a = 9'h001;
      else if (p < 40) a = 9'h010;
      else             a = 9'h002;
`else
      a = 9'h000;
`endif
    end
    return a;
  endfunction

  task automatic check_out(input string name, input logic [8:0] exp_act);
    logic [8:0] got;
    logic [8:0] want;
    got  = {ctrl_if.coin_left, ctrl_if.button_1p, ctrl_if.game_joystick1};
    want = ~exp_act;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at t=%0t ticks=%0d: got coin=%b start=%b joy=%h, want coin=%b start=%b joy=%h",
               name, $time, ticks, got[8], got[7], got[6:0], want[8], want[7], want[6:0]);
    end
  endtask

  // One cycle: check against the model, then drive inputs and account for the tick.
  task automatic step(input logic lv, input logic lr);
    @(negedge clk_i);
    check_out("track", model_act(ticks));
    ctrl_if.lvbl     = lv;
    ctrl_if.loop_rst = lr;
    if (lr) ticks = 0;
    else if (prev_lvbl && !lv) ticks++;
    prev_lvbl = lv;
  endtask

  task automatic frame(input int lo, input int hi);
    repeat (lo) step(1'b0, 1'b0);
    repeat (hi) step(1'b1, 1'b0);
  endtask

  task automatic rand_frame();
    frame($urandom_range(1, 3), $urandom_range(1, 4));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni           = 1'b0;
    ctrl_if.lvbl     = 1'b1;
    ctrl_if.loop_rst = 1'b0;
    ticks            = 0;
    prev_lvbl        = 1'b1;
    repeat (2) step(1'b1, 1'b0);
    rst_ni = 1'b1;
    step(1'b1, 1'b0);
  endtask

  task automatic run_to(input int n);
    while (ticks < n) rand_frame();
  endtask

  initial begin
    rst_ni           = 1'b0;
    ctrl_if.lvbl     = 1'b1;
    ctrl_if.loop_rst = 1'b0;

    vecs[0]  = '{59,  9'h000};
    vecs[1]  = '{60,  9'h100};
    vecs[2]  = '{63,  9'h100};
    vecs[3]  = '{64,  9'h000};
    vecs[4]  = '{93,  9'h000};
    vecs[5]  = '{94,  9'h080};
    vecs[6]  = '{97,  9'h080};
    vecs[7]  = '{98,  9'h000};
    vecs[8]  = '{217, 9'h000};
    vecs[9]  = '{218, 9'h001};
    vecs[10] = '{247, 9'h001};
    vecs[11] = '{248, 9'h010};
    vecs[12] = '{257, 9'h010};
    vecs[13] = '{258, 9'h002};
    vecs[14] = '{287, 9'h002};
`ifdef JTFRAME_TEST_INPUTS_LOOP_EN
    vecs[15] = '{288, 9'h001};
    vecs[16] = '{318, 9'h010};
    vecs[17] = '{358, 9'h001};
`else
    vecs[15] = '{288, 9'h000};
    vecs[16] = '{450, 9'h000};
    vecs[17] = '{588, 9'h000};
`endif

    do_reset();
    check_out("reset_state", 9'h000);

    // Whole script against the hand-derived table.
    for (int i = 0; i < 18; i++) begin
      run_to(vecs[i].edges);
      check_out($sformatf("vec%0d_edge%0d", i, vecs[i].edges), vecs[i].act);
    end

    // Restart coincident with a falling edge during S6.
    do_reset();
    run_to(250);
    check_out("in_s6", 9'h010);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_out("lrst_release", 9'h000);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (59) rand_frame();
    check_out("lrst_coin59", 9'h000);
    rand_frame();
    check_out("lrst_coin60", 9'h100);

    // LVBL held low for a long time counts as a single frame.
    do_reset();
    repeat (1000) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    repeat (58) rand_frame();
    check_out("long_low_59", 9'h000);
    rand_frame();
    check_out("long_low_60", 9'h100);

    // Asynchronous reset in the middle of S3.
    run_to(95);
    check_out("in_s3", 9'h080);
    @(negedge clk_i);
    rst_ni           = 1'b0;
    ctrl_if.lvbl     = 1'b1;
    ctrl_if.loop_rst = 1'b0;
    #1;
    check_out("async_rst", 9'h000);
    ticks     = 0;
    prev_lvbl = 1'b1;
    repeat (2) step(1'b1, 1'b0);
    rst_ni = 1'b1;

    // Random frame timing with occasional restarts, checked every cycle.
    for (int f = 0; f < 700; f++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
      end
      rand_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
